// File: rtl/lcd_pkg.sv
// Shared types, init command bytes and default timing for the LCD bus arbiter.
// Init support is built only when LCD_ARB_INIT_EN is defined.
package lcd_pkg;

   localparam int unsigned TIMER_W = 20;

   localparam int unsigned T_SETUP_DEF   = 2;
   localparam int unsigned T_PW_DEF      = 12;
   localparam int unsigned T_HOLD_DEF    = 2;
   localparam int unsigned T_CMD_DEF     = 2000;
   localparam int unsigned T_LONG_DEF    = 82000;
   localparam int unsigned T_POWERUP_DEF = 750000;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;

   typedef enum logic [2:0] {
      StPowerup,
      StInit,
      StIdle,
      StSetup,
      StPulse,
      StHold,
      StWait
   } lcd_state_e;

   // Timer reload for a phase of 'cycles' clocks; a zero length counts as one.
   function automatic logic [TIMER_W-1:0] phase_load(input int unsigned cycles);
      int unsigned eff;
      eff = (cycles == 0) ? 1 : cycles;
      return TIMER_W'(eff - 1);
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISP_ON;
         2'd2:    return CMD_ENTRY;
         default: return CMD_CLEAR;
      endcase
   endfunction

   // Clear and home commands need the long busy wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data >= 8'h01) && (data <= 8'h03);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable 20-bit down-counter; done is high whenever the count has reached zero.
module lcd_timer
   import lcd_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               load,
   input  logic [TIMER_W-1:0] value,
   output logic               done
);

   logic [TIMER_W-1:0] count_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= value;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter driving an HD44780-style LCD write bus.
// Define LCD_ARB_INIT_EN to build the power-up wait and init command sequence.
module lcd_bus_arbiter
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP   = T_SETUP_DEF,
   parameter int unsigned T_PW      = T_PW_DEF,
   parameter int unsigned T_HOLD    = T_HOLD_DEF,
   parameter int unsigned T_CMD     = T_CMD_DEF,
   parameter int unsigned T_LONG    = T_LONG_DEF,
   parameter int unsigned T_POWERUP = T_POWERUP_DEF
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req0,
   input  logic       req1,
   input  logic       rs0,
   input  logic       rs1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       ready,
   output logic       lcde,
   output logic       lcdrs,
   output logic       lcdrw,
   output logic [7:0] lcddata
);

   localparam logic [TIMER_W-1:0] LD_SETUP = phase_load(T_SETUP);
   localparam logic [TIMER_W-1:0] LD_PW    = phase_load(T_PW);
   localparam logic [TIMER_W-1:0] LD_HOLD  = phase_load(T_HOLD);
   localparam logic [TIMER_W-1:0] LD_CMD   = phase_load(T_CMD);
   localparam logic [TIMER_W-1:0] LD_LONG  = phase_load(T_LONG);

`ifdef LCD_ARB_INIT_EN
   localparam logic [TIMER_W-1:0] LD_POWERUP = phase_load(T_POWERUP);
   localparam lcd_state_e         ST_RESET   = StPowerup;
`else
   localparam lcd_state_e         ST_RESET   = StIdle;
`endif

   lcd_state_e         state_q, state_d;
   logic               ready_q, ready_d;
   logic               prio_q, prio_d;
   logic               ack0_q, ack0_d;
   logic               ack1_q, ack1_d;
   logic               rs_q, rs_d;
   logic [7:0]         data_q, data_d;
   logic               gnt1;
   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_value;
   logic               tmr_done;

`ifdef LCD_ARB_INIT_EN
   logic [1:0] idx_q, idx_d;
   logic       armed_q, armed_d;
`endif

   lcd_timer u_timer (
      .clk    (clk),
      .resetn (resetn),
      .load   (tmr_load),
      .value  (tmr_value),
      .done   (tmr_done)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_RESET;
         ready_q <= 1'b0;
         prio_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
`ifdef LCD_ARB_INIT_EN
         idx_q   <= 2'd0;
         armed_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         prio_q  <= prio_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
`ifdef LCD_ARB_INIT_EN
         idx_q   <= idx_d;
         armed_q <= armed_d;
`endif
      end
   end

   // Each phase loads the timer on entry and leaves when it reaches zero.
   always_comb begin
      state_d   = state_q;
      ready_d   = ready_q;
      prio_d    = prio_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      rs_d      = rs_q;
      data_d    = data_q;
      gnt1      = 1'b0;
      tmr_load  = 1'b0;
      tmr_value = '0;
`ifdef LCD_ARB_INIT_EN
      idx_d     = idx_q;
      armed_d   = armed_q;
`else
      ready_d   = 1'b1;
`endif
      case (state_q)
`ifdef LCD_ARB_INIT_EN
         StPowerup: begin
            if (!armed_q) begin
               armed_d   = 1'b1;
               tmr_load  = 1'b1;
               tmr_value = LD_POWERUP;
            end else if (tmr_done) begin
               state_d = StInit;
            end
         end
         StInit: begin
            rs_d      = 1'b0;
            data_d    = init_cmd(idx_q);
            tmr_load  = 1'b1;
            tmr_value = LD_SETUP;
            state_d   = StSetup;
         end
`endif
         StIdle: begin
            if (ready_q && (req0 || req1)) begin
               // prio_q set means requester 1 wins a tie.
               gnt1 = req1 && (!req0 || prio_q);
               if (gnt1) begin
                  rs_d   = rs1;
                  data_d = data1;
                  ack1_d = 1'b1;
                  prio_d = 1'b0;
               end else begin
                  rs_d   = rs0;
                  data_d = data0;
                  ack0_d = 1'b1;
                  prio_d = 1'b1;
               end
               tmr_load  = 1'b1;
               tmr_value = LD_SETUP;
               state_d   = StSetup;
            end
         end
         StSetup: begin
            if (tmr_done) begin
               tmr_load  = 1'b1;
               tmr_value = LD_PW;
               state_d   = StPulse;
            end
         end
         StPulse: begin
            if (tmr_done) begin
               tmr_load  = 1'b1;
               tmr_value = LD_HOLD;
               state_d   = StHold;
            end
         end
         StHold: begin
            if (tmr_done) begin
               tmr_load  = 1'b1;
               tmr_value = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_CMD;
               state_d   = StWait;
            end
         end
         StWait: begin
            if (tmr_done) begin
`ifdef LCD_ARB_INIT_EN
               if (ready_q) begin
                  state_d = StIdle;
               end else if (idx_q == 2'd3) begin
                  ready_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = StInit;
               end
`else
               state_d = StIdle;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign ready   = ready_q;
   assign lcde    = (state_q == StPulse);
   assign lcdrs   = rs_q;
   assign lcdrw   = 1'b0;
   assign lcddata = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Randomized self-checking bench for lcd_bus_arbiter against a transaction-level model.
// Checks the init sequence when LCD_ARB_INIT_EN is defined.
module tb_lcd_bus_arbiter;

   localparam int T_SETUP   = 1;
   localparam int T_PW      = 3;
   localparam int T_HOLD    = 1;
   localparam int T_CMD     = 5;
   localparam int T_LONG    = 20;
   localparam int T_POWERUP = 10;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       rs0 = 1'b0, rs1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       ack0, ack1, ready, lcde, lcdrs, lcdrw;
   logic [7:0] lcddata;

   lcd_bus_arbiter #(
      .T_SETUP   (T_SETUP),
      .T_PW      (T_PW),
      .T_HOLD    (T_HOLD),
      .T_CMD     (T_CMD),
      .T_LONG    (T_LONG),
      .T_POWERUP (T_POWERUP)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .req0    (req0),
      .req1    (req1),
      .rs0     (rs0),
      .rs1     (rs1),
      .data0   (data0),
      .data1   (data1),
      .ack0    (ack0),
      .ack1    (ack1),
      .ready   (ready),
      .lcde    (lcde),
      .lcdrs   (lcdrs),
      .lcdrw   (lcdrw),
      .lcddata (lcddata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Per-requester stimulus streams: the bench appends, the model consumes.
   logic [8:0] stim [2][512];
   int         n_push [2] = '{0, 0};
   int         n_pop  [2] = '{0, 0};

   task automatic push(input int i, input logic rs, input logic [7:0] d);
      stim[i][n_push[i]] = {rs, d};
      n_push[i]++;
   endtask

   logic [7:0] init_ref [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
   logic [8:0] exp_q [$];
   logic [8:0] rise_byte, gb;
   logic       model_on = 1'b0, le_prev = 1'b0, rst_prev = 1'b0, prio = 1'b0;
   int         next_free = 0, rise_c = 0, fall_c = 0, rel_c = 0, last_ack_c = 0;
   int         n_init = 0, g;

   // Bus monitor, arbitration model and request driver, all evaluated at negedge.
   always @(negedge clk) begin
      if (!resetn) begin
         model_on = 1'b0;
         le_prev  = 1'b0;
         rst_prev = 1'b0;
         n_init   = 0;
         exp_q.delete();
         for (int i = 0; i < 2; i++) n_pop[i] = n_push[i];
         req0 = 1'b0;
         req1 = 1'b0;
      end else begin
         if (!rst_prev) begin
            rel_c    = cyc;
            rst_prev = 1'b1;
         end
         if (lcde && !le_prev) begin
            rise_c    = cyc;
            rise_byte = {lcdrs, lcddata};
            check_eq("lcdrw_low", lcdrw, 0);
            if (!model_on) begin
               if (n_init == 0) check_eq("powerup_wait", (cyc - rel_c) >= T_POWERUP, 1);
               if (n_init < 4) check_eq("init_byte", rise_byte, {1'b0, init_ref[n_init]});
               n_init++;
            end else begin
               check_eq("pulse_pending", exp_q.size(), 1);
               check_eq("setup_time", cyc - last_ack_c, T_SETUP);
               if (exp_q.size() > 0) check_eq("pulse_byte", rise_byte, exp_q[0]);
            end
         end
         if (!lcde && le_prev) begin
            check_eq("e_width", cyc - rise_c, T_PW);
            check_eq("bus_stable", {lcdrs, lcddata}, rise_byte);
            fall_c = cyc;
            if (model_on && exp_q.size() > 0) void'(exp_q.pop_front());
         end
         le_prev = lcde;

         if (!model_on) begin
            check_eq("ack_before_ready", {ack0, ack1}, 0);
            if (ready) begin
               model_on  = 1'b1;
               next_free = cyc + 1;
               prio      = 1'b0;
`ifdef LCD_ARB_INIT_EN
               check_eq("init_count", n_init, 4);
               check_eq("clear_long_wait", cyc - fall_c, T_HOLD + T_LONG);
`else
               check_eq("init_count", n_init, 0);
`endif
            end
         end else begin
            check_eq("ready_held", ready, 1);
            g = -1;
            if (cyc >= next_free && (req0 || req1)) g = (req0 && req1) ? int'(prio) : (req0 ? 0 : 1);
            check_eq("ack0", ack0, g == 0);
            check_eq("ack1", ack1, g == 1);
            if (g >= 0) begin
               gb = (g == 0) ? {rs0, data0} : {rs1, data1};
               exp_q.push_back(gb);
               last_ack_c = cyc;
               prio       = (g == 0);
               next_free  = cyc + 1 + T_SETUP + T_PW + T_HOLD
                          + ((!gb[8] && gb[7:0] >= 8'h01 && gb[7:0] <= 8'h03) ? T_LONG : T_CMD);
               n_pop[g]++;
            end
         end

         req0 = (n_pop[0] < n_push[0]);
         if (req0) {rs0, data0} = stim[0][n_pop[0]];
         req1 = (n_pop[1] < n_push[1]);
         if (req1) {rs1, data1} = stim[1][n_pop[1]];
      end
   end

   task automatic wait_ready(input string tag);
      for (int k = 0; k < 3000 && !model_on; k++) @(negedge clk);
      check_eq(tag, model_on, 1);
   endtask

   task automatic drain(input string tag);
      logic idle;
      idle = 1'b0;
      for (int k = 0; k < 6000 && !idle; k++) begin
         @(negedge clk);
         idle = (n_pop[0] == n_push[0]) && (n_pop[1] == n_push[1]) &&
                (exp_q.size() == 0) && (cyc >= next_free);
      end
      check_eq(tag, idle, 1);
   endtask

   initial begin
      logic       rs;
      logic [7:0] d;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", ready, 0);
      check_eq("rst_bus", {lcde, lcdrs, lcdrw, lcddata}, 0);
      check_eq("rst_ack", {ack0, ack1}, 0);
      resetn = 1'b1;
      wait_ready("ready_timeout");

      push(0, 1'b1, 8'h41);
      drain("drain_single");

      push(1, 1'b0, 8'h01);
      @(negedge clk);
      push(0, 1'b1, 8'h42);
      drain("drain_long");

      push(1, 1'b1, 8'h5A);
      drain("drain_prio");

      for (int k = 0; k < 4; k++) begin
         push(0, 1'b1, 8'h30 + 8'(k));
         push(1, 1'b1, 8'h60 + 8'(k));
      end
      drain("drain_alternate");

      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 12)) @(negedge clk);
         rs = 1'($urandom_range(0, 1));
         d  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) begin
            rs = 1'b0;
            d  = 8'($urandom_range(1, 3));
         end
         push($urandom_range(0, 1), rs, d);
      end
      drain("drain_random");

      push(0, 1'b1, 8'h55);
      for (int k = 0; k < 200 && !lcde; k++) @(negedge clk);
      check_eq("reach_pulse", lcde, 1);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check_eq("abort_bus", {lcde, lcdrs, lcdrw, lcddata}, 0);
      check_eq("abort_ack", {ack0, ack1}, 0);
      check_eq("abort_ready", ready, 0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      wait_ready("ready_after_abort");

      push(1, 1'b0, 8'h80);
      drain("drain_final");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
- REQ-001 SHALL have parameter T_SETUP, default 2: clk cycles with RS/DATA valid and E low before the E pulse.
- REQ-002 SHALL have parameter T_PW, default 12: clk cycles E is high.
- REQ-003 SHALL have parameter T_HOLD, default 2: clk cycles with RS/DATA held and E low after the pulse.
- REQ-004 SHALL have parameter T_CMD, default 2000: busy wait after an ordinary write.
- REQ-005 SHALL have parameter T_LONG, default 82000: busy wait after clear (0x01) or home (0x02/0x03) with RS=0.
- REQ-006 SHALL have parameter T_POWERUP, default 750000: wait after reset before the first init command.
- REQ-007 SHALL have port clk, input, 1 bit: clock.
- REQ-008 SHALL have port resetn, input, 1 bit: reset; asynchronous, active-low.
- REQ-009 SHALL have ports req0/req1, input, 1 bit each: requester wants one byte written.
- REQ-010 SHALL have ports rs0/rs1, input, 1 bit each: 0 = command, 1 = character.
- REQ-011 SHALL have ports data0/data1, input, 8 bits each: byte to write.
- REQ-012 SHALL have ports ack0/ack1, output, 1 bit each: one-cycle pulse when the byte is captured.
- REQ-013 SHALL have port ready, output, 1 bit: init complete; requests are accepted.
- REQ-014 SHALL have ports lcde, lcdrs, lcdrw (outputs, 1 bit each) and lcddata (output, 8 bits): LCD bus.

Function
- REQ-015 SHALL implement states POWERUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT.
- REQ-016 SHALL, in POWERUP, count T_POWERUP cycles, then enter INIT.
- REQ-017 SHALL, in INIT, issue 0x38, 0x0C, 0x06, 0x01 with RS=0, in that order, each through SETUP/PULSE/HOLD/WAIT; after the last WAIT it SHALL set ready=1 and enter IDLE.
- REQ-018 SHALL, in IDLE with at least one req and ready=1, capture the granted rs/data into the output registers, pulse the granted ack for exactly one cycle, and enter SETUP on the next cycle.
- REQ-019 SHALL arbitrate round-robin: on simultaneous req0 and req1, grant the requester not served last; after reset, requester 0 has priority.
- REQ-020 SHALL hold SETUP for T_SETUP cycles (lcde=0), PULSE for T_PW cycles (lcde=1), HOLD for T_HOLD cycles (lcde=0), then WAIT.
- REQ-021 SHALL wait T_LONG cycles in WAIT when the written byte had RS=0 and data 0x01, 0x02 or 0x03; otherwise T_CMD cycles; then return to IDLE.
- REQ-022 SHALL keep lcdrs/lcddata stable from capture through the end of HOLD.
- REQ-023 SHALL drive lcdrw=0 at all times; there are no busy-flag reads.
- REQ-024 SHALL ignore req while not in IDLE or while ready=0: no ack is issued, and a held req is served at the next IDLE.
- REQ-025 SHALL have a minimum request-to-request spacing of 1 + T_SETUP + T_PW + T_HOLD + wait cycles; a requester keeping req high after ack gets a second write.
- REQ-026 SHALL treat any counter parameter of 0 as 1.

Reset
- REQ-027 SHALL, while resetn=0, immediately force lcde=0, lcdrs=0, lcdrw=0, lcddata=0x00, ack0=ack1=0, ready=0, round-robin pointer to requester 0, all counters 0, and state to POWERUP (or IDLE per REQ-029).
- REQ-028 SHALL abort any write in progress on reset mid-operation without acking or retrying it; the E pulse is truncated.

Configuration
- REQ-029 SHALL compile POWERUP and INIT in when macro LCD_ARB_INIT_EN is defined; without it, reset enters IDLE with ready=1 and no init command is ever issued.

Structure
- REQ-030 SHALL take the state encoding, init command constants (0x38, 0x0C, 0x06, 0x01) and default timing values from shared package lcd_pkg.
- REQ-031 SHALL use one sub-module lcd_timer: a 20-bit loadable down-counter with a done flag, used for every phase.

Verification (T_SETUP=1, T_PW=3, T_HOLD=1, T_CMD=5, T_LONG=20, T_POWERUP=10)
- REQ-032 SHALL verify: release reset with LCD_ARB_INIT_EN defined -> after 10 cycles, four E pulses carrying 0x38, 0x0C, 0x06, 0x01 (RS=0), each 3 cycles high; the 0x01 pulse is followed by a 20-cycle wait; then ready=1.
- REQ-033 SHALL verify: req0 with rs0=1, data0=0x41 in IDLE -> ack0 for 1 cycle; lcdrs=1, lcddata=0x41; lcde high exactly 3 cycles; the next grant no sooner than 11 cycles after ack.
- REQ-034 SHALL verify: req0 and req1 held high together -> acks alternate 0,1,0,1 and data appears on lcddata in matching order.
- REQ-035 SHALL verify: req1 with rs1=0, data1=0x01 -> 20-cycle WAIT; an immediately following req0 is acked no earlier than 26 cycles after ack1.
- REQ-036 SHALL verify: resetn asserted during PULSE -> lcde=0 and all outputs zero in the same cycle; after release, init restarts and no ack is issued for the aborted byte.
